uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
// - 8N1 UART receiver; the receive-side counterpart to the sum/latch UART transmitter.
// - Deserialises the uart_rxd line into bytes and presents each byte with a valid/ack handshake.
// - Flags framing and overrun errors.
// - Sits between the uio_in pad and downstream command/latch logic in the top-level wrapper.
// PARAMETERS
// - CLKS_PER_BIT  default 434  clk cycles per bit (50 MHz / 115200); minimum 4.
// - CNT_W         default 9    baud counter width; must satisfy 2**CNT_W > CLKS_PER_BIT.
// PORTS
// - clk         in   1  system clock, rising edge.
// - reset_n     in   1  asynchronous, active-low reset.
// - uart_rxd    in   1  serial input; idles high; asynchronous to clk.
// - rx_data     out  8  received byte, LSB = first data bit.
// - rx_valid    out  1  rx_data holds an unconsumed byte.
// - rx_ack      in   1  consumer accepts the byte; sampled only while rx_valid=1.
// - rx_busy     out  1  a frame is in progress (state != IDLE).
// - frame_err   out  1  one-cycle pulse: stop bit sampled low.
// - overrun_err out  1  sticky: a frame completed while rx_valid=1; cleared by rx_ack.
// BEHAVIOUR
// - Reset values: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun_err=0.
//   Synchroniser flops reset to 1. State = IDLE.
// - Input path: 2-flop synchroniser on uart_rxd; rxd_s is the 2nd flop output. All decisions use rxd_s.
// - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
// - IDLE: on rxd_s==0, clear the baud counter and go to START.
// - START: after CLKS_PER_BIT/2 cycles (mid start bit), sample rxd_s.
//   - 0: clear counter, go to DATA, bit index = 0.
//   - 1: false start; return to IDLE with no flags.
// - DATA: every CLKS_PER_BIT cycles, shift rxd_s into bit[idx] (LSB first).
//   After idx 7, go to STOP, or to PARITY when enabled.
// - STOP: after CLKS_PER_BIT cycles (mid stop bit), sample rxd_s.
//   - 1 and no parity error: deliver the byte.
//   - Otherwise: pulse frame_err for 1 cycle; drop the byte.
//   - Return to IDLE on the same edge. The next start edge is accepted immediately, so back-to-back frames work.
// - Deliver, rx_valid==0: rx_data <= shift reg, rx_valid <= 1 on the clk after the stop-bit sample.
// - Deliver, rx_valid==1: rx_data is NOT overwritten; overrun_err <= 1; the new byte is discarded.
// - rx_ack with rx_valid=1: rx_valid <= 0 and overrun_err <= 0 next cycle.
// - rx_ack with rx_valid=0: ignored.
// - Deliver and rx_ack in the same cycle: the ack consumes the old byte, the new byte loads, rx_valid stays 1, no overrun.
// - Latency: rx_valid rises ~9.5 bit times (+2 sync cycles +1) after the start-bit falling edge.
// - Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0 on each sample tick. No fractional correction.
// - A line held low (break): frame_err pulse, then IDLE. No new start is detected until rxd_s returns high then falls.
// - reset_n assertion mid-frame: immediate abort to reset values. The partial byte is lost.
// CONFIGURATION
// - Macro UART_RX_PARITY_EN, defined: adds a PARITY state after bit 7.
//   - Even parity is sampled mid-bit.
//   - A mismatch is reported as frame_err at stop and the byte is dropped.
//   - Frame length = 11 bits.
// - Macro undefined: 8N1 only. The PARITY state and its logic are absent; frame length = 10 bits.
// TESTING (bench CLKS_PER_BIT=16)
// - Reset: hold reset_n=0 with uart_rxd=1 -> all outputs 0, rx_busy=0.
// - Receive 0xA5 8N1 -> one rx_valid with rx_data=0xA5, frame_err=0; rx_ack -> rx_valid=0 next clk.
// - Glitch: uart_rxd low for 4 clks -> FSM back to IDLE, no rx_valid, no frame_err.
// - Stop bit driven 0 with data 0x3C -> frame_err pulses 1 clk, rx_valid stays 0.
// - Overrun: send 0x11, no ack, then send 0x22 -> rx_data=0x11, overrun_err=1; rx_ack clears both flags.
// - Back-to-back 0x00 then 0xFF, zero idle, ack each byte -> both bytes delivered in order.
// - Reset mid-DATA -> outputs at reset values; the next 0x5A frame is received correctly.
// - With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> valid 0x07; parity bit 0 -> frame_err.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - byte handshake and status bundle of the UART receiver
interface uart_rx_frame_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err,
        output overrun_err,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  frame_err,
        input  overrun_err,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - 8N1 UART receiver with valid/ack byte handshake and error flags
// Optional even-parity bit (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 9
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            uart_rxd,
    uart_rx_frame_if.master rx
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             wait_high_q, wait_high_d;
    logic             rxd_meta, rxd_s;
    logic             bit_tick;
    logic             deliver;
    logic             ferr_d;
    logic             stop_ok;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             frame_err_q;
    logic             overrun_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            wait_high_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            wait_high_q <= wait_high_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign bit_tick = (cnt_q == BIT_LAST);

`ifdef UART_RX_PARITY_EN
    assign stop_ok = rxd_s && !par_err_q;
`else
    assign stop_ok = rxd_s;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        wait_high_d = wait_high_q;
        deliver     = 1'b0;
        ferr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // After a break the line must go high again before a new start is armed.
                if (wait_high_q) begin
                    if (rxd_s) begin
                        wait_high_d = 1'b0;
                    end
                end else if (!rxd_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    par_err_d = rxd_s ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (stop_ok) begin
                        deliver = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                        if (!rxd_s) begin
                            wait_high_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= ferr_d;
            if (deliver) begin
                // A same-cycle ack frees the holding register, so the new byte loads cleanly.
                if (!rx_valid_q || rx.rx_ack) begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                    if (rx_valid_q) begin
                        overrun_q <= 1'b0;
                    end
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx.rx_ack) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
        end
    end

    assign rx.rx_data     = rx_data_q;
    assign rx.rx_valid    = rx_valid_q;
    assign rx.rx_busy     = (state_q != S_IDLE);
    assign rx.frame_err   = frame_err_q;
    assign rx.overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame
module tb_uart_rx_frame;
    localparam int CPB = 16;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic uart_rxd = 1'b1;

    uart_rx_frame_if rx ();

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .uart_rxd (uart_rxd),
        .rx       (rx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic [7:0] data;
        logic       par_good;
        logic       stop_bit;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[$];

    always @(negedge clk) begin
        if (rx.frame_err) ferr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_check();
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: byte 0x%0h delivered, expected none", rx.rx_data);
        end else begin
            check("rx_data", {24'h0, rx.rx_data}, {24'h0, exp_q.pop_front()});
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`else
        if (par_bit) begin end
`endif
        send_bit(stop_bit);
        uart_rxd = 1'b1;
    endtask

    task automatic wait_valid(input int max_cycles);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (rx.rx_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("valid_timeout", {31'h0, ok}, 32'h1);
    endtask

    task automatic ack_pulse();
        rx.rx_ack = 1'b1;
        @(negedge clk);
        rx.rx_ack = 1'b0;
        check("valid_after_ack", {31'h0, rx.rx_valid}, 32'h0);
    endtask

    task automatic collect(input int n);
        for (int k = 0; k < n; k++) begin
            wait_valid(400);
            pop_check();
            ack_pulse();
        end
    endtask

    initial begin
        int f0;
        logic pb;
        rx.rx_ack = 1'b0;

        // reset state
        reset_n  = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_data", {24'h0, rx.rx_data}, 32'h0);
        check("rst_rx_valid", {31'h0, rx.rx_valid}, 32'h0);
        check("rst_rx_busy", {31'h0, rx.rx_busy}, 32'h0);
        check("rst_frame_err", {31'h0, rx.frame_err}, 32'h0);
        check("rst_overrun", {31'h0, rx.overrun_err}, 32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // table-driven frames
        vecs.push_back('{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'h81, 1'b1, 1'b1, 1'b1, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'h07, 1'b0, 1'b1, 1'b0, 1'b1});
`endif
        foreach (vecs[v]) begin
            f0 = ferr_cnt;
            pb = vecs[v].par_good ? ^vecs[v].data : ~^vecs[v].data;
            if (vecs[v].exp_valid) exp_q.push_back(vecs[v].data);
            send_frame(vecs[v].data, pb, vecs[v].stop_bit);
            repeat (4) @(negedge clk);
            if (vecs[v].exp_valid) begin
                wait_valid(64);
                pop_check();
                ack_pulse();
            end else begin
                check("no_valid", {31'h0, rx.rx_valid}, 32'h0);
            end
            check("ferr_pulses", ferr_cnt - f0, {31'h0, vecs[v].exp_ferr});
            check("overrun_idle", {31'h0, rx.overrun_err}, 32'h0);
            repeat (2 * CPB) @(negedge clk);
        end

        // glitch shorter than half a bit
        f0 = ferr_cnt;
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", {31'h0, rx.rx_busy}, 32'h1);
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_idle", {31'h0, rx.rx_busy}, 32'h0);
        check("glitch_valid", {31'h0, rx.rx_valid}, 32'h0);
        check("glitch_ferr", ferr_cnt - f0, 32'h0);

        // overrun: second byte arrives while the first is unacknowledged
        exp_q.push_back(8'h11);
        send_frame(8'h11, ^8'h11, 1'b1);
        send_frame(8'h22, ^8'h22, 1'b1);
        repeat (4) @(negedge clk);
        wait_valid(64);
        check("overrun_set", {31'h0, rx.overrun_err}, 32'h1);
        pop_check();
        ack_pulse();
        check("overrun_clr", {31'h0, rx.overrun_err}, 32'h0);
        repeat (CPB) @(negedge clk);

        // back-to-back frames, zero idle
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        fork
            begin
                send_frame(8'h00, ^8'h00, 1'b1);
                send_frame(8'hFF, ^8'hFF, 1'b1);
            end
            collect(2);
        join
        check("b2b_drained", exp_q.size(), 32'h0);
        repeat (2 * CPB) @(negedge clk);

        // reset in the middle of the data bits
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("mid_busy", {31'h0, rx.rx_busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("midrst_data", {24'h0, rx.rx_data}, 32'h0);
        check("midrst_busy", {31'h0, rx.rx_busy}, 32'h0);
        check("midrst_valid", {31'h0, rx.rx_valid}, 32'h0);
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, ^8'h5A, 1'b1);
        collect(1);
        check("final_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
